dcache_coherence_ctrl: RTL and testbench

Per-CPU L1 data cache controller and the cache-side end of the MSI coherence bus. It serves datapath loads and stores from a direct-mapped, two-word-block array. It issues block fetches, upgrades and write-backs to the memory controller. When the memory controller snoops it, it answers with invalidates or by supplying dirty data.

---
 rtl/dcache_coherence_ctrl.sv | 284 ++++++++++++++++++++++++++++
 tb/tb_dcache_coherence_ctrl.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_coherence_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | dcache_coherence_ctrl: direct-mapped MSI L1 D-cache, cache side of bus.   |
// | Optional flush-on-halt via DCACHE_FLUSH_EN.  Revision: 1.0               |
// +--------------------------------------------------------------------------+
module dcache_coherence_ctrl #(
  parameter int SETS  = 8,
  parameter int CPUID = 0
) (
  input  logic        CLK,
  input  logic        nRST,
`ifdef DCACHE_FLUSH_EN
  input  logic        halt,
  output logic        flushed,
`endif
  input  logic        dmemREN,
  input  logic        dmemWEN,
  input  logic [31:0] dmemaddr,
  input  logic [31:0] dmemstore,
  output logic [31:0] dmemload,
  output logic        dhit,
  output logic        dREN,
  output logic        dWEN,
  output logic [31:0] daddr,
  output logic [31:0] dstore,
  input  logic [31:0] dload,
  input  logic        dwait,
  output logic        cctrans,
  output logic        ccwrite,
  input  logic        ccwait,
  input  logic        ccinv,
  input  logic [31:0] ccsnoopaddr
);

  localparam int IDXW = $clog2(SETS);
  localparam int TAGW = 29 - IDXW;
  localparam logic [1:0] c_ST_I = 2'd0;
  localparam logic [1:0] c_ST_S = 2'd1;
  localparam logic [1:0] c_ST_M = 2'd2;

  typedef enum logic [3:0] {
    IDLE, UPGRADE, WB1, WB2, FETCH1, FETCH2, SNP_WB1, SNP_WB2
`ifdef DCACHE_FLUSH_EN
    , FLUSH1, FLUSH2, FLUSH_DONE
`endif
  } state_e;

  state_e            state_q, state_d;
  logic [1:0]        st_q   [SETS];
  logic [TAGW-1:0]   tag_q  [SETS];
  logic [31:0]       data_q [SETS][2];
  logic [IDXW-1:0]   sidx_q;
  logic [TAGW-1:0]   stag_q;
`ifdef DCACHE_FLUSH_EN
  logic [IDXW-1:0]   fidx_q, fidx_d;
`endif

  logic [IDXW-1:0]   w_idx, w_sidx;
  logic [TAGW-1:0]   w_tag, w_stag;
  logic              w_wsel, w_req, w_hit, w_shit, w_snp_m, w_snp_inv_s;
  logic              w_unused_snp;

  // array update requests (one state write per cycle at most)
  logic              st_we, wd_we, tag_we, snp_take;
  logic [IDXW-1:0]   st_widx, wd_idx;
  logic [1:0]        st_wval;
  logic              wd_sel;
  logic [31:0]       wd_val;

  assign w_idx        = dmemaddr[2+IDXW:3];
  assign w_tag        = dmemaddr[31:3+IDXW];
  assign w_wsel       = dmemaddr[2];
  assign w_sidx       = ccsnoopaddr[2+IDXW:3];
  assign w_stag       = ccsnoopaddr[31:3+IDXW];
  assign w_req        = dmemREN | dmemWEN;
  assign w_hit        = (st_q[w_idx] != c_ST_I) && (tag_q[w_idx] == w_tag);
  assign w_shit       = (st_q[w_sidx] != c_ST_I) && (tag_q[w_sidx] == w_stag);
  assign w_snp_m      = w_shit && (st_q[w_sidx] == c_ST_M);
  assign w_snp_inv_s  = w_shit && (st_q[w_sidx] == c_ST_S) && ccinv;
  assign w_unused_snp = ^ccsnoopaddr[2:0];

  always_comb begin
    state_d  = state_q;
    dmemload = 32'h0;
    dhit     = 1'b0;
    dREN     = 1'b0;
    dWEN     = 1'b0;
    daddr    = 32'h0;
    dstore   = 32'h0;
    cctrans  = 1'b0;
    ccwrite  = 1'b0;
    st_we    = 1'b0;
    st_widx  = w_idx;
    st_wval  = c_ST_I;
    wd_we    = 1'b0;
    wd_idx   = w_idx;
    wd_sel   = w_wsel;
    wd_val   = dmemstore;
    tag_we   = 1'b0;
    snp_take = 1'b0;
`ifdef DCACHE_FLUSH_EN
    fidx_d   = fidx_q;
    flushed  = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        if (ccwait) begin
          snp_take = 1'b1;
`ifdef DCACHE_FLUSH_EN
        end else if (halt) begin
          state_d = FLUSH1;
`endif
        end else if (w_req) begin
          if (w_hit && !dmemWEN) begin
            dhit     = 1'b1;
            dmemload = data_q[w_idx][w_wsel];
          end else if (w_hit && (st_q[w_idx] == c_ST_M)) begin
            dhit  = 1'b1;
            wd_we = 1'b1;
          end else if (w_hit) begin
            state_d = UPGRADE;
          end else if (st_q[w_idx] == c_ST_M) begin
            state_d = WB1;
          end else begin
            state_d = FETCH1;
          end
        end
      end

      UPGRADE: begin
        if (ccwait) begin
          snp_take = 1'b1;
        end else begin
          cctrans = 1'b1;
          ccwrite = 1'b1;
          st_we   = 1'b1;
          st_wval = c_ST_M;
          state_d = IDLE;
        end
      end

      WB1, WB2: begin
        dWEN   = 1'b1;
        daddr  = {tag_q[w_idx], w_idx, (state_q == WB2), 2'b00};
        dstore = data_q[w_idx][state_q == WB2];
        if (!dwait) begin
          if (state_q == WB1) begin
            state_d = WB2;
          end else begin
            st_we   = 1'b1;
            st_wval = c_ST_I;
            state_d = FETCH1;
          end
        end
      end

      FETCH1, FETCH2: begin
        if (ccwait && (state_q == FETCH1)) begin
          snp_take = 1'b1;
        end else begin
          dREN    = 1'b1;
          cctrans = 1'b1;
          ccwrite = dmemWEN;
          daddr   = {w_tag, w_idx, (state_q == FETCH2), 2'b00};
          if (!dwait) begin
            wd_we  = 1'b1;
            wd_sel = (state_q == FETCH2);
            wd_val = dload;
            st_we  = 1'b1;
            if (state_q == FETCH1) begin
              // old contents are now partially overwritten; drop the line
              st_wval = c_ST_I;
              state_d = FETCH2;
            end else begin
              st_wval = dmemWEN ? c_ST_M : c_ST_S;
              tag_we  = 1'b1;
              state_d = IDLE;
            end
          end
        end
      end

      SNP_WB1, SNP_WB2: begin
        cctrans = 1'b1;
        daddr   = {stag_q, sidx_q, (state_q == SNP_WB2), 2'b00};
        dstore  = data_q[sidx_q][state_q == SNP_WB2];
        if (!dwait) begin
          if (state_q == SNP_WB1) begin
            state_d = SNP_WB2;
          end else begin
            st_we   = 1'b1;
            st_widx = sidx_q;
            st_wval = ccinv ? c_ST_I : c_ST_S;
            state_d = IDLE;
          end
        end
      end

`ifdef DCACHE_FLUSH_EN
      FLUSH1, FLUSH2: begin
        if (ccwait && (state_q == FLUSH1)) begin
          snp_take = 1'b1;
        end else if ((state_q == FLUSH1) && (st_q[fidx_q] != c_ST_M)) begin
          st_we   = 1'b1;
          st_widx = fidx_q;
          st_wval = c_ST_I;
          if (fidx_q == IDXW'(SETS - 1)) state_d = FLUSH_DONE;
          else fidx_d = fidx_q + IDXW'(1);
        end else begin
          dWEN   = 1'b1;
          daddr  = {tag_q[fidx_q], fidx_q, (state_q == FLUSH2), 2'b00};
          dstore = data_q[fidx_q][state_q == FLUSH2];
          if (!dwait) begin
            if (state_q == FLUSH1) begin
              state_d = FLUSH2;
            end else begin
              st_we   = 1'b1;
              st_widx = fidx_q;
              st_wval = c_ST_I;
              if (fidx_q == IDXW'(SETS - 1)) begin
                state_d = FLUSH_DONE;
              end else begin
                fidx_d  = fidx_q + IDXW'(1);
                state_d = FLUSH1;
              end
            end
          end
        end
      end

      FLUSH_DONE: begin
        flushed = 1'b1;
      end
`endif

      default: state_d = IDLE;
    endcase

    // snoop service shared by every state that yields to the controller
    if (snp_take) begin
      state_d = w_snp_m ? SNP_WB1 : IDLE;
      if (w_snp_inv_s) begin
        st_we   = 1'b1;
        st_widx = w_sidx;
        st_wval = c_ST_I;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (nRST) begin
      state_q <= IDLE;
      sidx_q  <= '0;
      stag_q  <= '0;
      for (int i = 0; i < SETS; i++) st_q[i] <= c_ST_I;
`ifdef DCACHE_FLUSH_EN
      fidx_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      if (st_we) st_q[st_widx] <= st_wval;
      if (snp_take) begin
        sidx_q <= w_sidx;
        stag_q <= w_stag;
      end
`ifdef DCACHE_FLUSH_EN
      fidx_q  <= fidx_d;
`endif
    end
  end

  // tag and data need no reset: state I masks them
  always_ff @(posedge CLK) begin
    if (wd_we)  data_q[wd_idx][wd_sel] <= wd_val;
    if (tag_we) tag_q[w_idx]           <= w_tag;
  end

  a_aligned: assert property (@(posedge CLK) disable iff (nRST)
                              w_req |-> (dmemaddr[1:0] == 2'b00))
    else $error("dcache%0d: misaligned access %h", CPUID, dmemaddr);

endmodule
`default_nettype wire

// File: tb/tb_dcache_coherence_ctrl.sv
`default_nettype none
// Bench for dcache_coherence_ctrl: MSI cache model with per-cycle output compare.
module tb_dcache_coherence_ctrl;
  localparam int SETS = 8;
  localparam int IDXW = $clog2(SETS);

  logic        CLK = 1'b0, nRST = 1'b1;
  logic        dmemREN = 0, dmemWEN = 0;
  logic [31:0] dmemaddr = 0, dmemstore = 0, dload = 0, ccsnoopaddr = 0;
  logic        dwait = 1, ccwait = 0, ccinv = 0;
  logic [31:0] dmemload, daddr, dstore;
  logic        dhit, dREN, dWEN, cctrans, ccwrite;

  dcache_coherence_ctrl #(.SETS(SETS), .CPUID(0)) dut (
    .CLK(CLK), .nRST(nRST), .dmemREN(dmemREN), .dmemWEN(dmemWEN),
    .dmemaddr(dmemaddr), .dmemstore(dmemstore), .dmemload(dmemload), .dhit(dhit),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .dload(dload),
    .dwait(dwait), .cctrans(cctrans), .ccwrite(ccwrite), .ccwait(ccwait),
    .ccinv(ccinv), .ccsnoopaddr(ccsnoopaddr)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0, n_fail = 0;
  bit chk_en = 0;

  // expected outputs for the current cycle
  logic        e_dREN, e_dWEN, e_cctrans, e_ccwrite, e_dhit;
  logic [31:0] e_daddr, e_dstore, e_load;
  bit          v_addr, v_store, v_load;

  // cache model: 0=I 1=S 2=M
  int          m_st   [SETS];
  int          m_tag  [SETS];
  logic [31:0] m_data [SETS][2];

  // observed history for literal pinning
  logic [31:0] acc_q[$];
  logic [31:0] snp_q[$];
  logic [31:0] last_load;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge CLK) begin
    if (chk_en) begin
      chk("dREN", dREN, e_dREN);
      chk("dWEN", dWEN, e_dWEN);
      chk("cctrans", cctrans, e_cctrans);
      chk("ccwrite", ccwrite, e_ccwrite);
      chk("dhit", dhit, e_dhit);
      if (v_addr)  chk("daddr", daddr, e_daddr);
      if (v_store) chk("dstore", dstore, e_dstore);
      if (v_load)  chk("dmemload", dmemload, e_load);
      if ((dREN || dWEN) && !dwait) acc_q.push_back(daddr);
      if (cctrans && !dREN && !ccwrite && !dwait) snp_q.push_back(dstore);
      if (dhit && dmemREN && !dmemWEN) last_load = dmemload;
    end
  end

  function automatic int f_idx(input logic [31:0] a); return int'((a >> 3) % SETS); endfunction
  function automatic int f_tag(input logic [31:0] a); return int'(a >> (3 + IDXW)); endfunction
  function automatic logic [31:0] blk(input int tg, input int idx);
    return 32'((tg * SETS + idx) * 8);
  endfunction

  task automatic step();
    @(posedge CLK); #1;
    e_dREN = 0; e_dWEN = 0; e_cctrans = 0; e_ccwrite = 0; e_dhit = 0;
    e_daddr = 0; e_dstore = 0; e_load = 0; v_addr = 0; v_store = 0; v_load = 0;
    dwait = 1; dload = 32'h0;
  endtask

  task automatic wb_word(input logic [31:0] a, input logic [31:0] d, input int ws);
    for (int k = 0; k <= ws; k++) begin
      step();
      dwait = (k < ws);
      e_dWEN = 1; e_daddr = a; v_addr = 1; e_dstore = d; v_store = 1;
    end
  endtask

  task automatic fetch_word(input logic [31:0] a, input bit wr, input logic [31:0] d, input int ws);
    for (int k = 0; k <= ws; k++) begin
      step();
      dwait = (k < ws);
      dload = (k < ws) ? 32'hDEADBEEF : d;
      e_dREN = 1; e_cctrans = 1; e_ccwrite = wr; e_daddr = a; v_addr = 1;
    end
  endtask

  task automatic snp_word(input logic [31:0] a, input logic [31:0] d);
    step();
    dwait = 0;
    e_cctrans = 1; e_daddr = a; v_addr = 1; e_dstore = d; v_store = 1;
  endtask

  task automatic access(input bit wr, input bit both, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] f0,
                        input logic [31:0] f1, input int ws);
    int idx, tg, w;
    bit hit;
    idx = f_idx(a); tg = f_tag(a); w = int'(a[2]);
    hit = (m_st[idx] != 0) && (m_tag[idx] == tg);
    step();
    dmemREN = !wr || both; dmemWEN = wr; dmemaddr = a; dmemstore = wd;
    if (hit && !wr) begin
      e_dhit = 1; e_load = m_data[idx][w]; v_load = 1;
    end else if (hit && m_st[idx] == 2) begin
      e_dhit = 1; m_data[idx][w] = wd;
    end else if (hit) begin
      step(); e_cctrans = 1; e_ccwrite = 1;
      m_st[idx] = 2;
      step(); e_dhit = 1; m_data[idx][w] = wd;
    end else begin
      if (m_st[idx] == 2) begin
        wb_word(blk(m_tag[idx], idx),     m_data[idx][0], ws);
        wb_word(blk(m_tag[idx], idx) + 4, m_data[idx][1], ws);
        m_st[idx] = 0;
      end
      fetch_word(blk(tg, idx),     wr, f0, ws);
      fetch_word(blk(tg, idx) + 4, wr, f1, ws);
      m_tag[idx] = tg; m_data[idx][0] = f0; m_data[idx][1] = f1;
      m_st[idx] = wr ? 2 : 1;
      step(); e_dhit = 1;
      if (wr) m_data[idx][w] = wd;
      else begin e_load = m_data[idx][w]; v_load = 1; end
    end
    step();
    dmemREN = 0; dmemWEN = 0; dmemaddr = 0;
  endtask

  task automatic snoop(input logic [31:0] a, input bit inv);
    int idx, tg;
    bit hit;
    idx = f_idx(a); tg = f_tag(a);
    hit = (m_st[idx] != 0) && (m_tag[idx] == tg);
    step();
    ccwait = 1; ccsnoopaddr = a; ccinv = inv;
    if (hit && m_st[idx] == 2) begin
      snp_word(blk(tg, idx),     m_data[idx][0]);
      snp_word(blk(tg, idx) + 4, m_data[idx][1]);
      m_st[idx] = inv ? 0 : 1;
    end else if (hit && inv) begin
      m_st[idx] = 0;
    end
    step();
    ccwait = 0; ccinv = 0; ccsnoopaddr = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < SETS; i++) begin m_st[i] = 0; m_tag[i] = 0; end
    last_load = 0;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_dREN", dREN, 0);   chk("rst_dWEN", dWEN, 0);
    chk("rst_cctrans", cctrans, 0); chk("rst_dhit", dhit, 0);
    chk("rst_daddr", daddr, 0); chk("rst_dmemload", dmemload, 0);
    nRST = 0;
    step();
    chk_en = 1;

    // read miss then hit path
    acc_q.delete();
    access(0, 0, 32'h104, 0, 32'hAAAA0001, 32'hAAAA0002, 0);
    chk("tp1_load", last_load, 32'hAAAA0002);
    chk("tp1_nacc", acc_q.size(), 2);
    chk("tp1_acc0", acc_q[0], 32'h100);
    chk("tp1_acc1", acc_q[1], 32'h104);

    // S write -> upgrade, then local read
    access(1, 0, 32'h100, 32'h12345678, 0, 0, 0);
    acc_q.delete();
    access(0, 0, 32'h100, 0, 0, 0, 0);
    chk("tp2_load", last_load, 32'h12345678);
    chk("tp2_nobus", acc_q.size(), 0);

    // snoop M with invalidate
    snp_q.delete();
    snoop(32'h104, 1);
    chk("tp3_nsnp", snp_q.size(), 2);
    chk("tp3_snp0", snp_q[0], 32'h12345678);
    chk("tp3_snp1", snp_q[1], 32'hAAAA0002);

    // write miss with wait states -> M, then conflict read miss with write-back
    access(1, 0, 32'h100, 32'hCAFE0100, 32'h11110000, 32'h11110004, 2);
    acc_q.delete();
    access(0, 0, 32'h140, 0, 32'h55550000, 32'h55550004, 1);
    chk("tp4_nacc", acc_q.size(), 4);
    chk("tp4_acc0", acc_q[0], 32'h100);
    chk("tp4_acc1", acc_q[1], 32'h104);
    chk("tp4_acc2", acc_q[2], 32'h140);
    chk("tp4_acc3", acc_q[3], 32'h144);
    chk("tp4_load", last_load, 32'h55550000);

    // snoop miss, snoop S keep, snoop S invalidate, re-read misses
    snoop(32'h200, 1);
    snoop(32'h144, 0);
    snoop(32'h140, 1);
    access(0, 0, 32'h144, 0, 32'h66660000, 32'h66660004, 0);
    chk("inv_refetch", last_load, 32'h66660004);

    // dirty line at set 1, then snoop it during FETCH1 of another miss
    access(1, 0, 32'h008, 32'h0000BEEF, 32'h77770000, 32'h77770004, 0);
    snp_q.delete();
    step(); dmemREN = 1; dmemaddr = 32'h010;
    step(); e_dREN = 1; e_cctrans = 1; e_daddr = 32'h010; v_addr = 1;
    step(); ccwait = 1; ccsnoopaddr = 32'h00C; ccinv = 0;
    snp_word(32'h008, m_data[1][0]);
    snp_word(32'h00C, m_data[1][1]);
    m_st[1] = 1;
    step(); ccwait = 0; ccsnoopaddr = 0;
    fetch_word(32'h010, 0, 32'h22220000, 0);
    fetch_word(32'h014, 0, 32'h22220004, 0);
    m_tag[2] = 0; m_data[2][0] = 32'h22220000; m_data[2][1] = 32'h22220004; m_st[2] = 1;
    step(); e_dhit = 1; e_load = 32'h22220000; v_load = 1;
    step(); dmemREN = 0; dmemaddr = 0;
    chk("fsnp_snp0", snp_q[0], 32'h0000BEEF);
    chk("fsnp_snp1", snp_q[1], 32'h77770004);
    chk("fsnp_load", last_load, 32'h22220000);

    // upgrade of set 1, then simultaneous REN+WEN counts as a write
    access(1, 0, 32'h00C, 32'h0C0C0C0C, 0, 0, 0);
    access(1, 1, 32'h008, 32'h08080808, 0, 0, 0);

    // reset while in WB2 of a conflict write miss
    step(); dmemWEN = 1; dmemaddr = 32'h048; dmemstore = 32'h48484848;
    wb_word(32'h008, 32'h08080808, 0);
    step();
    e_dWEN = 1; e_daddr = 32'h00C; v_addr = 1; e_dstore = 32'h0C0C0C0C; v_store = 1;
    nRST = 1;
    step(); nRST = 0; dmemWEN = 0; dmemaddr = 0;
    #1;
    chk("rst_mid_dWEN", dWEN, 0);
    chk("rst_mid_dhit", dhit, 0);
    for (int i = 0; i < SETS; i++) m_st[i] = 0;
    acc_q.delete();
    access(0, 0, 32'h008, 0, 32'h33330000, 32'h33330004, 1);
    chk("rst_refetch_n", acc_q.size(), 2);
    chk("rst_refetch", last_load, 32'h33330000);

    step();
    chk_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
